// File: rtl/setpoint_entry_if.sv
// setpoint_entry_if: operator-side signal bundle of the setpoint editor.
//   btnUp/btnDown/btnEnter : raw asynchronous pushbuttons, active high
//   displayMode            : 1 = decimal degrees, 0 = raw sensor units
//   dest                   : committed raw setpoint
//   editValue              : value under edit (BCD in decimal mode, binary in raw mode)
//   editing                : high while an edit or conversion is in progress
//   commitPulse            : one-cycle strobe accompanying each dest update
// master = stimulus/panel side, slave = setpoint_entry.
interface setpoint_entry_if;
   logic       btnUp;
   logic       btnDown;
   logic       btnEnter;
   logic       displayMode;
   logic [7:0] dest;
   logic [7:0] editValue;
   logic       editing;
   logic       commitPulse;

   modport master (
      output btnUp, btnDown, btnEnter, displayMode,
      input  dest, editValue, editing, commitPulse
   );

   modport slave (
      input  btnUp, btnDown, btnEnter, displayMode,
      output dest, editValue, editing, commitPulse
   );
endinterface

// File: rtl/setpoint_entry.sv
// setpoint_entry: pushbutton setpoint editor producing the raw target byte.
// Buttons are synchronized and debounced; Up/Down auto-repeat while held.
// Decimal entries are converted back to the raw scale (1 LSB = 50/256 deg)
// by a 14-step restoring divide before being committed to dest.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : setpoint_entry_if.slave (buttons, mode, dest, editValue, editing, commitPulse)
module setpoint_entry #(
   parameter logic [7:0] RESET_DEST      = 8'd102,
   parameter int         DEBOUNCE_CYCLES = 16,
   parameter int         REPEAT_DELAY    = 64,
   parameter int         REPEAT_PERIOD   = 16,
   parameter int         TIMEOUT_CYCLES  = 4096
) (
   input logic             clk,
   input logic             reset,
   setpoint_entry_if.slave bus
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int RW = $clog2(REPEAT_DELAY + 1) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [1:0] {S_IDLE, S_EDIT, S_CONVERT, S_COMMIT} state_t;

   state_t      state_reg, state_next;
   logic [2:0]  raw;            // {enter, down, up}
   logic [2:0]  level;
   logic [2:0]  press;
   logic [1:0]  step_raw;
   logic        step_up, step_dn, step_any, enter_ev;
   logic        mode, mode_d_reg;
   logic [7:0]  work_reg, dest_reg, limit, load_deg, shown, edit_value;
   logic        commit_pulse_reg, editing, commit_now;
   logic [13:0] prod, num_reg, quo_reg;
   logic [5:0]  rem_reg;
   logic [6:0]  trial;
   logic        trial_ge, dec_reg;
   logic [3:0]  div_cnt_reg;
   logic [TW-1:0] to_cnt_reg;

   assign raw  = {bus.btnEnter, bus.btnDown, bus.btnUp};
   assign mode = bus.displayMode;

   // Per-button synchronizer, debounce counter and rising-edge press event.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_btn
         logic          sync1_reg, sync2_reg, level_reg, level_d_reg;
         logic [DW-1:0] cnt_reg;
         always_ff @(posedge clk) begin
            if (reset) begin
               sync1_reg   <= 1'b0;
               sync2_reg   <= 1'b0;
               level_reg   <= 1'b0;
               level_d_reg <= 1'b0;
               cnt_reg     <= '0;
            end else begin
               sync1_reg   <= raw[gi];
               sync2_reg   <= sync1_reg;
               level_d_reg <= level_reg;
               if (sync2_reg == level_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
                  level_reg <= sync2_reg;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + DW'(1);
               end
            end
         end
         assign level[gi] = level_reg;
         assign press[gi] = level_reg & ~level_d_reg;
      end

      // Auto-repeat: rep_reg counts cycles since the press; after the first
      // repeat it is rewound so the next hit lands REPEAT_PERIOD later.
      for (gi = 0; gi < 2; gi++) begin : g_rep
         logic [RW-1:0] rep_reg;
         always_ff @(posedge clk) begin
            if (reset || !level[gi])
               rep_reg <= '0;
            else if (press[gi])
               rep_reg <= RW'(1);
            else if (rep_reg == RW'(REPEAT_DELAY))
               rep_reg <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
            else
               rep_reg <= rep_reg + RW'(1);
         end
         assign step_raw[gi] = press[gi] |
                               (level[gi] & ~press[gi] & (rep_reg == RW'(REPEAT_DELAY)));
      end
   endgenerate

   // Holding both Up and Down is treated as a conflict: no steps at all.
   assign step_up  = step_raw[0] & ~(level[0] & level[1]);
   assign step_dn  = step_raw[1] & ~(level[0] & level[1]);
   assign step_any = step_up | step_dn;
   assign enter_ev = press[2];

   // Raw -> rounded degrees; adding 128 before the shift rounds on bit 7.
   assign prod     = dest_reg * 6'd50;
   assign load_deg = 8'((prod + 14'd128) >> 8);
   assign limit    = mode ? 8'd49 : 8'd255;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         mode_d_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         mode_d_reg <= mode;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:    if (step_any) state_next = S_EDIT;
         S_EDIT: begin
            if (mode != mode_d_reg)
               state_next = S_IDLE;
            else if (enter_ev)
               state_next = mode ? S_CONVERT : S_COMMIT;
            else if (!step_any && to_cnt_reg == TW'(TIMEOUT_CYCLES - 1))
               state_next = S_IDLE;
         end
         S_CONVERT: if (div_cnt_reg == 4'd13) state_next = S_COMMIT;
         S_COMMIT:  state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   always_comb begin
      editing    = 1'b0;
      commit_now = 1'b0;
      shown      = work_reg;
      case (state_reg)
         S_IDLE:    shown = mode ? load_deg : dest_reg;
         S_EDIT,
         S_CONVERT: editing = 1'b1;
         S_COMMIT:  commit_now = 1'b1;
         default:   ;
      endcase
      edit_value = mode ? {4'(shown / 8'd10), 4'(shown % 8'd10)} : shown;
   end

   // Working register: first step only opens the edit; Enter beats a step.
   always_ff @(posedge clk) begin
      if (reset) begin
         work_reg <= 8'd0;
      end else if (state_reg == S_IDLE) begin
         if (step_any) work_reg <= mode ? load_deg : dest_reg;
      end else if (state_reg == S_EDIT && !enter_ev && mode == mode_d_reg) begin
         if (step_up && work_reg < limit)
            work_reg <= work_reg + 8'd1;
         else if (step_dn && work_reg != 8'd0)
            work_reg <= work_reg - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || state_reg != S_EDIT || step_any)
         to_cnt_reg <= '0;
      else
         to_cnt_reg <= to_cnt_reg + TW'(1);
   end

   // Restoring divide of work*256+25 by 50, MSB first. dec_reg remembers
   // which path was taken so a mode flip during CONVERT cannot alter it.
   assign trial    = {rem_reg, num_reg[13]};
   assign trial_ge = (trial >= 7'd50);

   always_ff @(posedge clk) begin
      if (reset) begin
         num_reg     <= '0;
         quo_reg     <= '0;
         rem_reg     <= '0;
         div_cnt_reg <= '0;
         dec_reg     <= 1'b0;
      end else if (state_reg == S_EDIT &&
                   (state_next == S_CONVERT || state_next == S_COMMIT)) begin
         num_reg     <= {work_reg[5:0], 8'd25};
         quo_reg     <= '0;
         rem_reg     <= '0;
         div_cnt_reg <= '0;
         dec_reg     <= (state_next == S_CONVERT);
      end else if (state_reg == S_CONVERT) begin
         num_reg     <= {num_reg[12:0], 1'b0};
         rem_reg     <= trial_ge ? 6'(trial - 7'd50) : trial[5:0];
         quo_reg     <= {quo_reg[12:0], trial_ge};
         div_cnt_reg <= div_cnt_reg + 4'd1;
      end
   end

   // A work value of 50 (loadable from dest=255) would divide to 256; clamp.
   always_ff @(posedge clk) begin
      if (reset) begin
         dest_reg         <= RESET_DEST;
         commit_pulse_reg <= 1'b0;
      end else begin
         commit_pulse_reg <= commit_now;
         if (commit_now)
            dest_reg <= dec_reg ? ((quo_reg > 14'd255) ? 8'hFF : quo_reg[7:0]) : work_reg;
      end
   end

   assign bus.dest        = dest_reg;
   assign bus.editValue   = edit_value;
   assign bus.editing     = editing;
   assign bus.commitPulse = commit_pulse_reg;
endmodule

// File: tb/tb_setpoint_entry.sv
module tb_setpoint_entry;
   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   int   pulse_cnt = 0;
   int   p0;
   logic seen_edit;

   setpoint_entry_if bus();

   setpoint_entry #(
      .RESET_DEST(8'd102), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8),
      .REPEAT_PERIOD(4), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.commitPulse === 1'b1) pulse_cnt++;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Short clean press (released before auto-repeat can fire) plus settle.
   task automatic press(input int idx);
      case (idx)
         0: bus.btnUp = 1'b1;
         1: bus.btnDown = 1'b1;
         default: bus.btnEnter = 1'b1;
      endcase
      tick(7);
      bus.btnUp = 1'b0; bus.btnDown = 1'b0; bus.btnEnter = 1'b0;
      tick(10);
      $display("press btn%0d: editing=%b editValue=%h dest=%h", idx, bus.editing, bus.editValue, bus.dest);
   endtask

   task automatic hold(input int idx, input int n);
      if (idx == 0) bus.btnUp = 1'b1; else bus.btnDown = 1'b1;
      tick(n);
      bus.btnUp = 1'b0; bus.btnDown = 1'b0;
      tick(10);
      $display("hold btn%0d %0d cycles: editValue=%h", idx, n, bus.editValue);
   endtask

   // Enter press; latency counted in negedges from the raw rising input.
   task automatic enter_commit(input string tag, input int exp_lat);
      int lat;
      int q0;
      lat = 0;
      q0 = pulse_cnt;
      bus.btnEnter = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         tick(1);
         if (i == 7) bus.btnEnter = 1'b0;
         if (lat == 0 && bus.commitPulse === 1'b1) begin
            lat = i;
            chk({tag, "_editing_at_pulse"}, {7'd0, bus.editing}, 8'h00);
         end
      end
      chk_int({tag, "_latency"}, lat, exp_lat);
      chk_int({tag, "_pulses"}, pulse_cnt - q0, 1);
      $display("enter %s: latency=%0d dest=%h", tag, lat, bus.dest);
   endtask

   initial begin
      bus.btnUp = 1'b0; bus.btnDown = 1'b0; bus.btnEnter = 1'b0;
      bus.displayMode = 1'b1;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(2);
      chk("rst_dest", bus.dest, 8'h66);
      chk("rst_editing", {7'd0, bus.editing}, 8'h00);
      chk("rst_pulse", {7'd0, bus.commitPulse}, 8'h00);
      chk("rst_editvalue", bus.editValue, 8'h20);

      // Decimal entry: 20 -> 21 degrees -> raw 108.
      press(0);
      chk("dec_open_editing", {7'd0, bus.editing}, 8'h01);
      chk("dec_open_value", bus.editValue, 8'h20);
      press(0);
      chk("dec_up_value", bus.editValue, 8'h21);
      enter_commit("dec21", 22);
      chk("dec21_dest", bus.dest, 8'h6C);
      chk("dec21_idle_value", bus.editValue, 8'h21);

      // Held Up saturates at 49 degrees -> raw 251.
      hold(0, 400);
      chk("dec_sat_editing", {7'd0, bus.editing}, 8'h01);
      chk("dec_sat_value", bus.editValue, 8'h49);
      enter_commit("dec49", 22);
      chk("dec49_dest", bus.dest, 8'hFB);

      // Raw mode: reach 255, then confirm saturation at the top.
      bus.displayMode = 1'b0;
      tick(2);
      chk("raw_idle_value", bus.editValue, 8'hFB);
      hold(0, 60);
      chk("raw_up_value", bus.editValue, 8'hFF);
      enter_commit("raw255a", 8);
      chk("raw255a_dest", bus.dest, 8'hFF);
      press(0);
      press(0);
      chk("raw_top_value", bus.editValue, 8'hFF);
      enter_commit("raw255b", 8);
      chk("raw255b_dest", bus.dest, 8'hFF);

      // Down to 0, then bottom saturation.
      hold(1, 1200);
      chk("raw_down_value", bus.editValue, 8'h00);
      enter_commit("raw0", 8);
      chk("raw0_dest", bus.dest, 8'h00);
      press(1);
      chk("raw_bot_open", {7'd0, bus.editing}, 8'h01);
      chk("raw_bot_value0", bus.editValue, 8'h00);
      press(1);
      chk("raw_bot_value1", bus.editValue, 8'h00);

      // Idle timeout abandons the edit.
      p0 = pulse_cnt;
      tick(80);
      chk("timeout_editing", {7'd0, bus.editing}, 8'h00);
      chk_int("timeout_pulses", pulse_cnt - p0, 0);
      chk("timeout_dest", bus.dest, 8'h00);
      $display("timeout: editing=%b dest=%h", bus.editing, bus.dest);

      // Bouncy Up never debounces into a press.
      p0 = pulse_cnt;
      seen_edit = 1'b0;
      for (int i = 0; i < 40; i++) begin
         bus.btnUp = ((i / 2) % 2 == 0);
         tick(1);
         seen_edit = seen_edit | bus.editing;
      end
      bus.btnUp = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         seen_edit = seen_edit | bus.editing;
      end
      chk("bounce_editing", {7'd0, seen_edit}, 8'h00);
      chk("bounce_dest", bus.dest, 8'h00);
      chk_int("bounce_pulses", pulse_cnt - p0, 0);
      $display("bounce: editing_seen=%b dest=%h", seen_edit, bus.dest);

      // Reset five cycles into CONVERT.
      bus.displayMode = 1'b1;
      tick(2);
      press(0);
      chk("cvt_open_editing", {7'd0, bus.editing}, 8'h01);
      p0 = pulse_cnt;
      bus.btnEnter = 1'b1;
      tick(7);
      bus.btnEnter = 1'b0;
      tick(4);
      chk("cvt_in_progress", {7'd0, bus.editing}, 8'h01);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(40);
      chk("cvt_rst_dest", bus.dest, 8'h66);
      chk("cvt_rst_editing", {7'd0, bus.editing}, 8'h00);
      chk("cvt_rst_value", bus.editValue, 8'h20);
      chk_int("cvt_rst_pulses", pulse_cnt - p0, 0);
      $display("reset in convert: dest=%h editing=%b", bus.dest, bus.editing);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
